// File: rtl/axis_link_checker_pkg.sv
// axis_link_checker_pkg: pattern mode encodings, checker
// state encoding and PRBS-7 tap positions.
package axis_link_checker_pkg;

   localparam logic [1:0] MODE_INC  = 2'd0;
   localparam logic [1:0] MODE_PRBS = 2'd1;

   // x^7 + x^6 + 1: feedback from stages 7 and 6
   localparam int PRBS7_TAP_A = 6;
   localparam int PRBS7_TAP_B = 5;

   typedef enum logic [1:0] {
      SEEK    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   function automatic logic mode_valid(input logic [1:0] m);
      return (m == MODE_INC) || (m == MODE_PRBS);
   endfunction

endpackage

// File: rtl/axis_link_checker_next.sv
// pattern_next: combinational successor of a pattern word.
// Shared by the checker and the matching pattern generator.
module pattern_next #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] cur,
   output logic [DATA_WIDTH-1:0] nxt
);
   import axis_link_checker_pkg::*;

   logic [6:0]            lfsr;
   logic [DATA_WIDTH-1:0] prbs;

   // Run the LFSR from cur[6:0], emitting DATA_WIDTH bits MSB first
   always_comb begin
      lfsr = 7'(cur);
      prbs = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         lfsr = {lfsr[5:0], lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B]};
         prbs[i] = lfsr[0];
      end
   end

   // Select the successor for the active mode
   always_comb begin
      unique case (mode)
         MODE_PRBS: nxt = prbs;
         default:   nxt = cur + 1'b1;
      endcase
   end

endmodule

// File: rtl/axis_link_checker.sv
// axis_link_checker: self-synchronising AXI-Stream pattern
// checker with error, frame, beat and lock-loss statistics.
module axis_link_checker #(
   parameter int DATA_WIDTH  = 8,
   parameter int FRAME_SIZE  = 4,
   parameter int LOCK_COUNT  = 4,
   parameter int LOSS_COUNT  = 8,
   parameter int CNT_WIDTH   = 16,
   parameter bit CHECK_TLAST = 1'b1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [1:0]            mode,
   input  logic                  clear,
   output logic                  locked,
   output logic                  err_pulse,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic [CNT_WIDTH-1:0]  frame_err_count,
   output logic [CNT_WIDTH-1:0]  lock_loss_count
);
   import axis_link_checker_pkg::*;

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);
   localparam int PW = $clog2(FRAME_SIZE + 1);

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [DATA_WIDTH-1:0] nxt_exp, nxt_dat;
   logic [MW-1:0]         match_q, match_d;
   logic [LW-1:0]         consec_q, consec_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic [1:0]            mode_q;
   cnt_t                  beat_d, err_d, ferr_d, loss_d;
   logic                  done_d, pulse_d;
   logic                  beat, hit, last_due;

   pattern_next #(.DATA_WIDTH(DATA_WIDTH)) u_next_exp (
      .mode (mode),
      .cur  (exp_q),
      .nxt  (nxt_exp)
   );

   pattern_next #(.DATA_WIDTH(DATA_WIDTH)) u_next_dat (
      .mode (mode),
      .cur  (s_axis_tdata),
      .nxt  (nxt_dat)
   );

   assign beat     = s_axis_tvalid & s_axis_tready;
   assign hit      = (s_axis_tdata == exp_q);
   assign last_due = (pos_q == PW'(FRAME_SIZE - 1));
   assign locked   = (state_q == LOCKED);

   // Next-state, expectation, frame position and statistics
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      match_d  = match_q;
      consec_d = consec_q;
      pos_d    = pos_q;
      beat_d   = beat_count;
      err_d    = error_count;
      ferr_d   = frame_err_count;
      loss_d   = lock_loss_count;
      done_d   = done;
      pulse_d  = 1'b0;

      if (mode != mode_q && state_q != SEEK) begin
         state_d  = SEEK;
         match_d  = '0;
         consec_d = '0;
      end else if (beat) begin
         unique case (state_q)
            SEEK: begin
               if (mode_valid(mode)) begin
                  exp_d   = nxt_dat;
                  match_d = '0;
                  state_d = CONFIRM;
               end
            end
            CONFIRM: begin
               if (hit) begin
                  exp_d = nxt_exp;
                  if (match_q == MW'(LOCK_COUNT - 1)) begin
                     state_d  = LOCKED;
                     consec_d = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  exp_d   = nxt_dat;
                  match_d = '0;
               end
            end
            LOCKED: begin
               exp_d  = nxt_exp;
               beat_d = sat_inc(beat_count);
               if (hit) begin
                  consec_d = '0;
                  if (&s_axis_tdata) done_d = 1'b1;
               end else begin
                  err_d   = sat_inc(error_count);
                  pulse_d = 1'b1;
                  if (consec_q == LW'(LOSS_COUNT - 1)) begin
                     state_d  = SEEK;
                     consec_d = '0;
                     loss_d   = sat_inc(lock_loss_count);
                  end else begin
                     consec_d = consec_q + 1'b1;
                  end
               end
            end
            default: state_d = SEEK;
         endcase
      end

      if (beat) begin
         if (CHECK_TLAST && (s_axis_tlast != last_due))
            ferr_d = sat_inc(frame_err_count);
         pos_d = (s_axis_tlast || last_due) ? '0 : pos_q + 1'b1;
      end

      if (clear) begin
         beat_d = '0;
         err_d  = '0;
         ferr_d = '0;
         loss_d = '0;
         done_d = 1'b0;
      end
   end

   // State and registered outputs; ready rises after reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q         <= SEEK;
         exp_q           <= '0;
         match_q         <= '0;
         consec_q        <= '0;
         pos_q           <= '0;
         mode_q          <= MODE_INC;
         s_axis_tready   <= 1'b0;
         err_pulse       <= 1'b0;
         done            <= 1'b0;
         beat_count      <= '0;
         error_count     <= '0;
         frame_err_count <= '0;
         lock_loss_count <= '0;
      end else begin
         state_q         <= state_d;
         exp_q           <= exp_d;
         match_q         <= match_d;
         consec_q        <= consec_d;
         pos_q           <= pos_d;
         mode_q          <= mode;
         s_axis_tready   <= 1'b1;
         err_pulse       <= pulse_d;
         done            <= done_d;
         beat_count      <= beat_d;
         error_count     <= err_d;
         frame_err_count <= ferr_d;
         lock_loss_count <= loss_d;
      end
   end

endmodule

// File: tb/tb_axis_link_checker.sv
// tb_axis_link_checker: directed scenarios plus random
// traffic checked against a behavioural link model.
module tb_axis_link_checker;

   localparam int FRAME  = 4;
   localparam int LOCK_N = 4;
   localparam int LOSS_N = 8;
   localparam int CMAX   = 65535;

   logic        aclk = 1'b0;
   logic        areset;
   logic [7:0]  tdata;
   logic        tvalid, tready, tlast;
   logic [1:0]  mode;
   logic        clear;
   logic        locked, err_pulse, done;
   logic [15:0] beat_count, error_count;
   logic [15:0] frame_err_count, lock_loss_count;

   int errors = 0;
   int checks = 0;

   // model of the link as seen by the checker
   bit         m_ready, m_done, m_pulse;
   int         m_phase;
   logic [7:0] m_exp;
   int         m_run, m_bad, m_pos;
   int         m_beats, m_errs, m_ferrs, m_losses;
   logic [1:0] m_prev;
   int         tpos;

   axis_link_checker #(
      .DATA_WIDTH(8), .FRAME_SIZE(FRAME), .LOCK_COUNT(LOCK_N),
      .LOSS_COUNT(LOSS_N), .CNT_WIDTH(16), .CHECK_TLAST(1'b1)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .s_axis_tdata    (tdata),
      .s_axis_tvalid   (tvalid),
      .s_axis_tready   (tready),
      .s_axis_tlast    (tlast),
      .mode            (mode),
      .clear           (clear),
      .locked          (locked),
      .err_pulse       (err_pulse),
      .done            (done),
      .beat_count      (beat_count),
      .error_count     (error_count),
      .frame_err_count (frame_err_count),
      .lock_loss_count (lock_loss_count)
   );

   always #5 aclk = ~aclk;

   function automatic logic [7:0] predict(input logic [1:0] md,
                                          input logic [7:0] w);
      bit h [0:14];
      logic [7:0] r;
      if (md != 2'd1) return w + 8'd1;
      for (int k = 0; k < 7; k++) h[k] = w[6-k];
      for (int n = 7; n < 15; n++) h[n] = h[n-7] ^ h[n-6];
      for (int k = 0; k < 8; k++) r[7-k] = h[7+k];
      return r;
   endfunction

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d,
                             input logic l, input logic c);
      bit b;
      if (areset) begin
         m_ready = 0; m_phase = 0; m_exp = '0;
         m_run = 0; m_bad = 0; m_pos = 0;
         m_beats = 0; m_errs = 0; m_ferrs = 0; m_losses = 0;
         m_done = 0; m_pulse = 0; m_prev = 2'd0;
         return;
      end
      b = v && m_ready;
      m_ready = 1;
      m_pulse = 0;
      if (mode != m_prev && m_phase != 0) begin
         m_phase = 0; m_run = 0; m_bad = 0;
      end else if (b) begin
         if (m_phase == 0) begin
            if (mode < 2'd2) begin
               m_exp = predict(mode, d); m_run = 0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (d == m_exp) begin
               m_exp = predict(mode, m_exp);
               m_run++;
               if (m_run == LOCK_N) begin
                  m_phase = 2; m_bad = 0;
               end
            end else begin
               m_exp = predict(mode, d); m_run = 0;
            end
         end else begin
            m_beats = sat(m_beats + 1);
            if (d == m_exp) begin
               m_bad = 0;
               if (d == 8'hFF) m_done = 1;
            end else begin
               m_errs = sat(m_errs + 1);
               m_pulse = 1;
               m_bad++;
               if (m_bad == LOSS_N) begin
                  m_phase = 0; m_bad = 0;
                  m_losses = sat(m_losses + 1);
               end
            end
            m_exp = predict(mode, m_exp);
         end
      end
      if (b) begin
         if (l != (m_pos == FRAME - 1)) m_ferrs = sat(m_ferrs + 1);
         m_pos = (l || m_pos == FRAME - 1) ? 0 : m_pos + 1;
      end
      if (c) begin
         m_beats = 0; m_errs = 0; m_ferrs = 0; m_losses = 0;
         m_done = 0;
      end
      m_prev = mode;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tready", 32'(tready), 32'(m_ready));
      chk("locked", 32'(locked), 32'(m_phase == 2));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("done", 32'(done), 32'(m_done));
      chk("beat_count", 32'(beat_count), m_beats);
      chk("error_count", 32'(error_count), m_errs);
      chk("frame_err", 32'(frame_err_count), m_ferrs);
      chk("lock_loss", 32'(lock_loss_count), m_losses);
   endtask

   task automatic check_zero(input string tag);
      logic [31:0] any;
      any = 32'(tready) | 32'(locked) | 32'(err_pulse) | 32'(done)
          | 32'(beat_count) | 32'(error_count)
          | 32'(frame_err_count) | 32'(lock_loss_count);
      chk(tag, any, 32'd0);
   endtask

   task automatic step(input logic v, input logic [7:0] d,
                       input logic l, input logic c);
      @(negedge aclk);
      tvalid = v; tdata = d; tlast = l; clear = c;
      @(posedge aclk);
      model_edge(v, d, l, c);
      #1;
      check_all();
   endtask

   task automatic send_c(input logic [7:0] d, input logic c);
      step(1'b1, d, tpos == FRAME - 1, c);
      tpos = (tpos + 1) % FRAME;
   endtask

   task automatic send(input logic [7:0] d);
      send_c(d, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      areset = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_zero(tag);
      areset = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      tpos = 0;
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] x;
      logic [7:0] src;
      logic [7:0] seq [0:19];
      int r;

      areset = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
      mode = 2'd0; clear = 1'b0; tpos = 0;
      model_edge(1'b0, 8'h00, 1'b0, 1'b0);

      // 1: incrementing stream, lock after 5 beats, terminator
      do_reset("reset_zero");
      chk("tready_up", 32'(tready), 32'd1);
      for (int i = 0; i < 16; i++) begin
         send(8'(i));
         if (i == 3) chk("s1_not_locked", 32'(locked), 32'd0);
         if (i == 4) chk("s1_locked", 32'(locked), 32'd1);
      end
      chk("s1_beats", 32'(beat_count), 32'd11);
      chk("s1_errors", 32'(error_count), 32'd0);
      chk("s1_no_done", 32'(done), 32'd0);
      for (int i = 16; i < 256; i++) send(8'(i));
      chk("s1_done", 32'(done), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clear_done", 32'(done), 32'd0);
      chk("clear_keeps_lock", 32'(locked), 32'd1);

      // 2: single corrupt word costs exactly one error
      for (int i = 0; i < 32; i++) send(8'(i));
      send(8'h55);
      chk("s2_err", 32'(error_count), 32'd1);
      chk("s2_pulse", 32'(err_pulse), 32'd1);
      send(8'h21);
      chk("s2_pulse_gone", 32'(err_pulse), 32'd0);
      chk("s2_err_hold", 32'(error_count), 32'd1);
      for (int i = 8'h22; i <= 8'h30; i++) send(8'(i));

      // 3: stream jump loses lock after 8 errors, then relocks
      for (int i = 0; i < 8; i++) send(8'(8'h80 + i));
      chk("s3_err", 32'(error_count), 32'd9);
      chk("s3_unlocked", 32'(locked), 32'd0);
      chk("s3_loss", 32'(lock_loss_count), 32'd1);
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h88 + i));
         if (i == 3) chk("s3_not_yet", 32'(locked), 32'd0);
      end
      chk("s3_relock", 32'(locked), 32'd1);
      mode = 2'd1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("mode_chg_unlock", 32'(locked), 32'd0);
      chk("mode_chg_loss", 32'(lock_loss_count), 32'd1);
      mode = 2'd0;
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // 4: PRBS-7 from seed 0x7F locks; INC mode does not
      do_reset("reset_prbs");
      mode = 2'd1;
      w = 8'h7F;
      for (int i = 0; i < 20; i++) begin
         seq[i] = w;
         send(w);
         if (i == 3) chk("s4_not_locked", 32'(locked), 32'd0);
         if (i == 4) chk("s4_locked", 32'(locked), 32'd1);
         w = predict(2'd1, w);
      end
      chk("s4_errors", 32'(error_count), 32'd0);
      chk("s4_beats", 32'(beat_count), 32'd15);
      mode = 2'd0;
      do_reset("reset_inc");
      for (int i = 0; i < 20; i++) send(seq[i]);
      chk("s4_inc_never", 32'(locked), 32'd0);

      // 5: early tlast then missing tlast
      do_reset("reset_frame");
      x = 8'h40;
      for (int i = 0; i < 8; i++) begin send(x); x++; end
      step(1'b1, x, 1'b0, 1'b0); x++;
      step(1'b1, x, 1'b0, 1'b0); x++;
      step(1'b1, x, 1'b1, 1'b0); x++;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, x, 1'b0, 1'b0); x++;
      end
      tpos = 0;
      for (int i = 0; i < 4; i++) begin send(x); x++; end
      chk("s5_ferr", 32'(frame_err_count), 32'd2);
      chk("s5_err", 32'(error_count), 32'd0);

      // 6: clear with an error beat, then reset mid-frame
      send_c(x + 8'h40, 1'b1); x++;
      chk("s6_err_cleared", 32'(error_count), 32'd0);
      chk("s6_pulse", 32'(err_pulse), 32'd1);
      send(x); x++;
      chk("s6_still_locked", 32'(locked), 32'd1);
      areset = 1'b1;
      step(1'b1, x, 1'b0, 1'b0);
      check_zero("s6_midreset");
      areset = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      tpos = 0;

      // random traffic against the model
      src = 8'($urandom);
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            areset = 1'b1;
            step(1'b0, 8'h00, 1'b0, 1'b0);
            areset = 1'b0;
         end else if (r < 20) begin
            if (r < 5) mode = 2'($urandom_range(0, 2));
            step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
         end else begin
            w = predict(mode, src);
            if (r < 24) begin
               w = 8'($urandom);
               src = w;
            end else if (r < 28) begin
               w = w ^ 8'h10;
               src = predict(mode, src);
            end else begin
               src = w;
            end
            step(1'b1, w,
                 (r < 30) ? 1'($urandom) : (tpos == FRAME - 1),
                 1'($urandom_range(0, 39) == 0));
            tpos = (tpos + 1) % FRAME;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
